spi_bus_arbiter: RTL and testbench

- Shares the single SPI master on the Pmod header between up to NUM_REQ device sequencers: accelerometer, magnetometer and altimeter polling state machines.
- Arbitrates requests round-robin and drives the master's start/tx_data handshake.
- Routes the master's chip select to the granted device's CS line and returns the received word with a done pulse.
- Enforces an inter-transaction guard gap and a start-handshake timeout.

---
 rtl/spi_bus_arbiter.sv | 87 ++++++++
 tb/tb_spi_bus_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI master among NUM_REQ device sequencers
module spi_bus_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int GAP_CYCLES = 15,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_tx,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [15:0]            rx_data,
  output logic                   err,
  output logic                   spi_start,
  output logic [15:0]            spi_tx,
  input  logic                   spi_busy,
  input  logic [15:0]            spi_rx,
  input  logic                   spi_cs,
  output logic [NUM_REQ-1:0]     dev_cs_n
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, START, XFER, GAP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr, off, win;
  logic [IW:0] sum;
  logic [NUM_REQ-1:0] rot;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic tmo, gap_end;
  assign rot = NUM_REQ'({req, req} >> rr);
  assign sum = {1'b0, rr} + {1'b0, off};
  assign win = sum >= (IW+1)'(NUM_REQ) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
  assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign gap_end = gcnt == GW'(GAP_CYCLES - 1);
  // distance from the rr pointer to the first requesting slot
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) off = IW'(i);
  end
  // next-state: grant only once the master is idle, finish on busy fall or timeout
  always_comb begin
    state_nx = state == IDLE  ? (!spi_busy && |req ? START : IDLE) :
               state == START ? (spi_busy ? XFER : tmo ? GAP : START) :
               state == XFER  ? (spi_busy ? XFER : GAP) :
                                (gap_end ? IDLE : GAP);
  end
  // state register plus registered handshake, grant and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      spi_start <= 1'b0;
      spi_tx    <= '0;
      rx_data   <= '0;
      rr        <= '0;
      tcnt      <= '0;
      gcnt      <= '0;
    end else begin
      state <= state_nx;
      done  <= '0;
      err   <= 1'b0;
      tcnt  <= state == START ? tcnt + 1'b1 : '0;
      gcnt  <= state == GAP && !gap_end ? gcnt + 1'b1 : '0;
      if (state == IDLE && state_nx == START) begin
        grant     <= NUM_REQ'(1) << win;
        spi_tx    <= req_tx[{win, 4'b0000} +: 16];
        spi_start <= 1'b1;
        rr        <= win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
      end
      if (state == START && state_nx != START) spi_start <= 1'b0;
      if (state != GAP && state_nx == GAP) begin
        grant   <= '0;
        done    <= grant;
        err     <= state == START;
        rx_data <= state == XFER ? spi_rx : '0;
      end
    end
  end
  // the granted device follows the master's CS; everyone else stays deselected
  always_comb dev_cs_n = rst ? '1 : ~grant | {NUM_REQ{spi_cs}};
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: scoreboard bench for the round-robin SPI bus arbiter
module tb_spi_bus_arbiter;
  localparam int N = 3, G = 15, T = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, grant, done, dev_cs_n;
  logic [16*N-1:0] req_tx = '0;
  logic [15:0] rx_data, spi_tx, spi_rx = '0;
  logic err, spi_start, spi_busy = 1'b0, spi_cs;
  assign spi_cs = ~spi_busy;
  always #5 clk = ~clk;
  typedef struct {logic [N-1:0] g; logic [15:0] tx;} gnt_t;
  typedef struct {logic [N-1:0] d; logic [15:0] rx; logic e;} dn_t;
  typedef struct {int len; logic [15:0] rx;} mst_t;
  gnt_t gnt_q[$];
  dn_t done_q[$];
  mst_t mst_q[$];
  int total = 0, bad = 0, cyc = 0, gcyc = 0, ldone = -1;
  bit stuck = 1'b0;
  logic [N-1:0] pgrant = '0;

  spi_bus_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_tx(req_tx), .grant(grant), .done(done),
    .rx_data(rx_data), .err(err), .spi_start(spi_start), .spi_tx(spi_tx),
    .spi_busy(spi_busy), .spi_rx(spi_rx), .spi_cs(spi_cs), .dev_cs_n(dev_cs_n));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic xfer(input logic [N-1:0] g, input logic [15:0] tx, input logic [15:0] rx, input int len);
    gnt_q.push_back('{g, tx});
    mst_q.push_back('{len, rx});
    done_q.push_back('{g, rx, 1'b0});
  endtask

  task automatic wait_grant(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (grant == '0 && n < 300);
    if (grant == '0) chk({nm, "_grant_wait"}, 0, 1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (done == '0 && n < 300);
    if (done == '0) chk({nm, "_done_wait"}, 0, 1);
  endtask

  task automatic wait_busy(input string nm);
    int n = 0;
    while (!spi_busy && n < 300) begin @(negedge clk); n++; end
    if (!spi_busy) chk({nm, "_busy_wait"}, 0, 1);
  endtask

  // SPI master model: answers each spi_start with a busy window and a received word
  mst_t m;
  initial forever begin
    @(posedge clk); #1;
    if (spi_start && !stuck && mst_q.size() > 0) begin
      m = mst_q.pop_front();
      spi_busy = 1'b1;
      repeat (m.len) @(posedge clk);
      #1;
      spi_rx = m.rx;
      spi_busy = 1'b0;
    end
  end

  // monitor: pops expected grants/completions as the DUT presents them
  gnt_t eg;
  dn_t ed;
  logic [N-1:0] ecs;
  initial forever begin
    @(negedge clk); #1;
    cyc++;
    for (int i = 0; i < N; i++) ecs[i] = (rst || !grant[i]) ? 1'b1 : spi_cs;
    chk("dev_cs_n", 32'(dev_cs_n), 32'(ecs));
    chk("grant_onehot0", 32'($onehot0(grant)), 1);
    if (grant != '0 && pgrant == '0) begin
      if (gnt_q.size() == 0) chk("unexpected_grant", 32'(grant), 0);
      else begin
        eg = gnt_q.pop_front();
        chk("grant", 32'(grant), 32'(eg.g));
        chk("spi_tx", 32'(spi_tx), 32'(eg.tx));
        chk("spi_start_at_grant", 32'(spi_start), 1);
        if (ldone >= 0) chk("gap_len_ok", 32'(cyc - ldone >= G + 1), 1);
        gcyc = cyc;
      end
    end
    if (done != '0) begin
      chk("done_in_prev_grant", 32'(done & ~pgrant), 0);
      chk("spi_start_at_done", 32'(spi_start), 0);
      if (done_q.size() == 0) chk("unexpected_done", 32'(done), 0);
      else begin
        ed = done_q.pop_front();
        chk("done", 32'(done), 32'(ed.d));
        chk("rx_data", 32'(rx_data), 32'(ed.rx));
        chk("err", 32'(err), 32'(ed.e));
        if (ed.e) chk("timeout_len", cyc - gcyc, T);
      end
      ldone = cyc;
    end else chk("err_without_done", 32'(err), 0);
    pgrant = grant;
  end

  int early, n;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_start", 32'(spi_start), 0);
    chk("rst_spi_tx", 32'(spi_tx), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_cs", 32'(dev_cs_n), 32'h7);
    rst = 1'b0;
    // single requester
    req_tx[15:0] = 16'hA800;
    xfer(3'b001, 16'hA800, 16'h00C5, 34);
    req = 3'b001;
    wait_done("single");
    req = '0;
    repeat (G + 4) @(negedge clk);
    // three held requests from a fresh pointer
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req_tx = {16'h1020, 16'hA900, 16'hA800};
    xfer(3'b001, 16'hA800, 16'h1111, 5);
    xfer(3'b010, 16'hA900, 16'h2222, 7);
    xfer(3'b100, 16'h1020, 16'h3333, 4);
    req = 3'b111;
    repeat (3) begin wait_done("all3"); req = req & ~done; end
    repeat (G + 4) @(negedge clk);
    // pointer rotation
    req_tx = {16'hB200, 16'hB100, 16'hB000};
    xfer(3'b010, 16'hB100, 16'h0011, 3);
    xfer(3'b001, 16'hB000, 16'h0012, 3);
    xfer(3'b100, 16'hB200, 16'h0013, 3);
    xfer(3'b001, 16'hB000, 16'h0014, 3);
    xfer(3'b010, 16'hB100, 16'h0015, 3);
    req = 3'b010;
    wait_grant("rr1");
    req = 3'b011;
    wait_done("rr1");
    wait_done("rr0");
    req = 3'b100;
    wait_grant("rr2");
    req = 3'b111;
    wait_done("rr2");
    req = 3'b011;
    wait_done("rr0b");
    req = 3'b010;
    wait_done("rr1b");
    req = '0;
    repeat (G + 4) @(negedge clk);
    // start-handshake timeout then recovery
    stuck = 1'b1;
    req_tx[15:0] = 16'h5555;
    gnt_q.push_back('{3'b001, 16'h5555});
    done_q.push_back('{3'b001, 16'h0000, 1'b1});
    req = 3'b001;
    wait_done("tmo");
    stuck = 1'b0;
    req = '0;
    req_tx[31:16] = 16'h6666;
    xfer(3'b010, 16'h6666, 16'h7777, 6);
    req = 3'b010;
    wait_done("recover");
    req = '0;
    repeat (G + 4) @(negedge clk);
    // reset while the master is mid-transfer
    req_tx[15:0] = 16'h1234;
    gnt_q.push_back('{3'b001, 16'h1234});
    mst_q.push_back('{40, 16'h4321});
    xfer(3'b001, 16'h1234, 16'h4444, 5);
    req = 3'b001;
    wait_grant("xrst");
    wait_busy("xrst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("xrst_grant", 32'(grant), 0);
    chk("xrst_start", 32'(spi_start), 0);
    chk("xrst_cs", 32'(dev_cs_n), 32'h7);
    rst = 1'b0;
    early = 0; n = 0;
    while (spi_busy && n < 100) begin
      @(negedge clk); n++;
      if (spi_busy && grant != '0) early++;
    end
    chk("no_grant_while_busy", early, 0);
    wait_done("xrst2");
    req = '0;
    repeat (G + 4) @(negedge clk);
    // requester drops during transfer
    req_tx[47:32] = 16'hABCD;
    xfer(3'b100, 16'hABCD, 16'hBEEF, 20);
    req = 3'b100;
    wait_busy("drop");
    req = '0;
    wait_done("drop");
    repeat (G + 10) @(negedge clk);
    chk("drop_no_regrant", 32'(grant), 0);
    chk("rx_hold", 32'(rx_data), 32'hBEEF);
    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
